vospi_packet_parser: RTL and testbench

Parses the byte-packed 32-bit AXI-Stream produced by the VoSPI SPI master into a 16-bit Lepton pixel stream with frame and line markers. Video packets are 164 bytes, carried as 41 input words: a 4-byte header (ID and CRC) followed by 80 pixels. The block drops discard packets (ID[11:8]=4'hF) and enforces packet-number sequencing 0..LINES-1, resynchronising on packet 0. It sits between the SPI master and the frame buffer / video DMA.

---
 rtl/vospi_packet_parser_pkg.sv | 32 +++
 rtl/vospi_packet_parser_if.sv | 22 ++
 rtl/vospi_word_unpack.sv | 61 ++++++
 rtl/vospi_packet_parser.sv | 106 ++++++++++
 tb/tb_vospi_packet_parser.sv | 364 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vospi_packet_parser_pkg.sv
// Shared VoSPI constants, the parser state type and the header field helpers.
// Used by the packet parser and the word unpacker.
package vospi_packet_parser_pkg;

  localparam logic [15:0] DISCARD_MASK = 16'h0F00;  // ID[11:8] all ones marks a discard packet
  localparam logic [15:0] NUM_MASK     = 16'h0FFF;  // ID[11:0] is the packet number

  typedef enum logic [1:0] {
    HDR,
    PIX,
    DROP
  } state_t;

  // First 16-bit VoSPI item of a packed word: bytes 0 and 1, big-endian.
  function automatic logic [15:0] item_a(input logic [31:0] w);
    return {w[7:0], w[15:8]};
  endfunction

  // Second 16-bit VoSPI item of a packed word: bytes 2 and 3, big-endian.
  function automatic logic [15:0] item_b(input logic [31:0] w);
    return {w[23:16], w[31:24]};
  endfunction

  function automatic logic is_discard(input logic [15:0] id);
    return (id & DISCARD_MASK) == DISCARD_MASK;
  endfunction

  function automatic logic id_matches(input logic [15:0] id, input logic [11:0] num);
    return (id & NUM_MASK) == {4'h0, num};
  endfunction

endpackage

// File: rtl/vospi_packet_parser_if.sv
// Stream bundle around the parser: packed 32-bit words in, 16-bit pixels out.
// The slave modport is the parser's view; master is the surrounding system.
interface vospi_packet_parser_if;
  logic [31:0] s_tdata;
  logic        s_tvalid;
  logic        s_tready;
  logic [15:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tuser;
  logic        m_tlast;

  modport slave (
    input  s_tdata, s_tvalid, m_tready,
    output s_tready, m_tdata, m_tvalid, m_tuser, m_tlast
  );

  modport master (
    output s_tdata, s_tvalid, m_tready,
    input  s_tready, m_tdata, m_tvalid, m_tuser, m_tlast
  );
endinterface

// File: rtl/vospi_word_unpack.sv
// 32->16 unpacker: holds one packed word and presents item A then item B,
// carrying start-of-frame, end-of-line and end-of-frame tags with the pixels.
module vospi_word_unpack
  import vospi_packet_parser_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] word,
  input  logic        sof,
  input  logic        eol,
  input  logic        eof,
  output logic        ready,
  output logic [15:0] m_tdata,
  output logic        m_tvalid,
  input  logic        m_tready,
  output logic        m_tuser,
  output logic        m_tlast,
  output logic        m_teof
);

  logic [31:0] hold;
  logic        half;   // 0: item A on the output, 1: item B
  logic        sof_r;
  logic        eol_r;
  logic        eof_r;

  // A new word fits when nothing is presented or item B leaves this cycle.
  assign ready    = !m_tvalid || (half && m_tready);
  assign m_tdata  = half ? item_b(hold) : item_a(hold);
  assign m_tuser  = m_tvalid && !half && sof_r;
  assign m_tlast  = m_tvalid && half && eol_r;
  assign m_teof   = m_tvalid && half && eof_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the hold register is reset too because it drives m_tdata directly.
      hold     <= '0;
      half     <= 1'b0;
      m_tvalid <= 1'b0;
      sof_r    <= 1'b0;
      eol_r    <= 1'b0;
      eof_r    <= 1'b0;
    end else if (load) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      hold     <= word;
      half     <= 1'b0;
      m_tvalid <= 1'b1;
      sof_r    <= sof;
      eol_r    <= eol;
      eof_r    <= eof;
    end else if (m_tvalid && m_tready) begin
      if (!half) begin
        half <= 1'b1;
      end else begin
        m_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/vospi_packet_parser.sv
// VoSPI packet parser: header check, discard filtering and packet-number
// sequencing around a 32->16 unpacker that produces the Lepton pixel stream.
module vospi_packet_parser
  import vospi_packet_parser_pkg::*;
#(
  parameter int LINES  = 60,
  parameter int PIXELS = 80
) (
  input  logic                 clk,
  input  logic                 rst_n,
  vospi_packet_parser_if.slave bus,
  output logic                 in_sync,
  output logic                 sync_err,
  output logic                 frame_done
);

  localparam int WORDS = PIXELS / 2;
  localparam int CW    = $clog2(WORDS + 1);
  localparam int EW    = $clog2(LINES);

  state_t        state;
  logic [CW-1:0] wcnt;
  logic [EW-1:0] expected;
  logic          ready_en;
  logic          unpack_ready;
  logic          accept;
  logic          last_word;
  logic          m_teof;
  logic [15:0]   hdr_id;

  assign hdr_id        = item_a(bus.s_tdata);
  // ready_en keeps s_tready low while reset is asserted and high from the first clock after.
  assign bus.s_tready  = ready_en && ((state != PIX) || unpack_ready);
  assign accept        = bus.s_tvalid && bus.s_tready;
  assign last_word     = (wcnt == CW'(WORDS));

  vospi_word_unpack u_unpack (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept && (state == PIX)),
    .word     (bus.s_tdata),
    .sof      ((wcnt == CW'(1)) && (expected == '0)),
    .eol      (last_word),
    .eof      (last_word && (expected == EW'(LINES - 1))),
    .ready    (unpack_ready),
    .m_tdata  (bus.m_tdata),
    .m_tvalid (bus.m_tvalid),
    .m_tready (bus.m_tready),
    .m_tuser  (bus.m_tuser),
    .m_tlast  (bus.m_tlast),
    .m_teof   (m_teof)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= HDR;
      wcnt       <= '0;
      expected   <= '0;
      ready_en   <= 1'b0;
      in_sync    <= 1'b0;
      sync_err   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      ready_en   <= 1'b1;
      sync_err   <= 1'b0;
      frame_done <= bus.m_tvalid && bus.m_tready && m_teof;

      if (accept) begin
        wcnt <= last_word ? '0 : wcnt + CW'(1);
      end

      case (state)
        HDR: begin
          if (accept) begin
            if (is_discard(hdr_id)) begin
              state <= DROP;
            end else if (id_matches(hdr_id, 12'(expected))) begin
              state   <= PIX;
              in_sync <= 1'b1;
            end else begin
              state    <= DROP;
              sync_err <= in_sync;
              in_sync  <= 1'b0;
              expected <= '0;
            end
          end
        end
        // The line is complete once its last word is in the unpacker; the tags
        // travel with the pixels, so the next header can be taken right away.
        PIX: begin
          if (accept && last_word) begin
            state    <= HDR;
            expected <= (expected == EW'(LINES - 1)) ? '0 : expected + EW'(1);
          end
        end
        DROP: begin
          if (accept && last_word) begin
            state <= HDR;
          end
        end
        default: state <= HDR;
      endcase
    end
  end

endmodule

// File: tb/tb_vospi_packet_parser.sv
// Directed bench for the VoSPI packet parser: a pixel scoreboard fed by the
// scenario tasks, plus per-scenario checks on sync, error and frame pulses.
module tb_vospi_packet_parser;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_sync;
  logic sync_err;
  logic frame_done;

  vospi_packet_parser_if bus ();

  vospi_packet_parser #(.LINES(60), .PIXELS(80)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .in_sync    (in_sync),
    .sync_err   (sync_err),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    logic        u;
    logic        l;
  } pix_t;

  pix_t        exp_q[$];
  pix_t        exp_item;
  int          tests = 0;
  int          failed = 0;
  int          out_count = 0;
  int          se_count = 0;
  int          fd_count = 0;
  int          fd_gap = 0;
  int          stall_seen = 0;
  int          ncyc = 0;
  int          pcyc = 0;
  int          last_tl_cyc = 0;
  bit          stall_en = 1'b0;
  bit          prev_stall = 1'b0;
  logic [15:0] prev_d;
  logic        prev_u;
  logic        prev_l;

  always @(posedge clk) pcyc++;

  // Random backpressure, active only while a scenario enables it.
  initial forever begin
    @(posedge clk);
    #1;
    if (stall_en) bus.m_tready = 1'($urandom_range(0, 1));
  end

  // Output monitor and pixel scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        tests++;
        stall_seen++;
        if (bus.m_tvalid !== 1'b1 || bus.m_tdata !== prev_d ||
            bus.m_tuser !== prev_u || bus.m_tlast !== prev_l) begin
          failed++;
          $display("FAIL stall_hold: got valid=%b data=%h user=%b last=%b, required valid=1 data=%h user=%b last=%b",
                   bus.m_tvalid, bus.m_tdata, bus.m_tuser, bus.m_tlast, prev_d, prev_u, prev_l);
        end
      end
      if (bus.m_tvalid && bus.m_tready) begin
        out_count++;
        tests++;
        if (exp_q.size() == 0) begin
          failed++;
          $display("FAIL unexpected_pixel: got data=%h, required no output", bus.m_tdata);
        end else begin
          exp_item = exp_q.pop_front();
          if ({bus.m_tdata, bus.m_tuser, bus.m_tlast} !== {exp_item.d, exp_item.u, exp_item.l}) begin
            failed++;
            $display("FAIL pixel: got data=%h user=%b last=%b, required data=%h user=%b last=%b",
                     bus.m_tdata, bus.m_tuser, bus.m_tlast, exp_item.d, exp_item.u, exp_item.l);
          end
        end
        if (bus.m_tlast) last_tl_cyc = ncyc;
      end
      if (sync_err) se_count++;
      if (frame_done) begin
        fd_count++;
        fd_gap = ncyc - last_tl_cyc;
      end
      prev_stall = bus.m_tvalid && !bus.m_tready;
      prev_d     = bus.m_tdata;
      prev_u     = bus.m_tuser;
      prev_l     = bus.m_tlast;
      ncyc++;
    end
  end

  function automatic logic [31:0] enc(input logic [15:0] p0, input logic [15:0] p1);
    return {p1[7:0], p1[15:8], p0[7:0], p0[15:8]};
  endfunction

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] w);
    int n;
    n = 0;
    bus.s_tdata  = w;
    bus.s_tvalid = 1'b1;
    @(negedge clk);
    while (!bus.s_tready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.s_tready) begin
      tests++;
      failed++;
      $display("FAIL accept_timeout: s_tready=0 after %0d cycles, required 1", n);
    end
    @(posedge clk);
    #1;
    bus.s_tvalid = 1'b0;
  endtask

  // One 41-word packet; pixel k of a packet tagged t is {t, k}.
  task automatic send_packet(input logic [15:0] id, input logic [7:0] tag,
                             input bit expect_out, input bit sof, input bit byte_test);
    logic [15:0] p0;
    logic [15:0] p1;
    send_word({8'hA5, 8'h5A, id[7:0], id[15:8]});
    for (int i = 0; i < 40; i++) begin
      p0 = {tag, 8'(2 * i)};
      p1 = {tag, 8'(2 * i + 1)};
      if (byte_test && i == 0) begin
        p0 = 16'h1122;
        p1 = 16'h3344;
      end
      if (expect_out) begin
        exp_q.push_back(pix_t'{d: p0, u: sof && (i == 0), l: 1'b0});
        exp_q.push_back(pix_t'{d: p1, u: 1'b0, l: (i == 39)});
      end
      if (byte_test && i == 0) send_word(32'h44332211);
      else send_word(enc(p0, p1));
    end
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      failed++;
      $display("FAIL %s_drain: %0d pixels still expected, required 0", name, exp_q.size());
    end
    align();
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    align();
  endtask

  task automatic test_reset();
    bus.s_tvalid = 1'b0;
    bus.s_tdata  = '0;
    bus.m_tready = 1'b1;
    rst_n        = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if ({bus.s_tready, bus.m_tvalid, bus.m_tdata, bus.m_tuser, bus.m_tlast, in_sync, sync_err, frame_done} !== '0) begin
      failed++;
      $display("FAIL reset_values: got s_tready=%b m_tvalid=%b m_tdata=%h user=%b last=%b in_sync=%b sync_err=%b frame_done=%b, required all 0",
               bus.s_tready, bus.m_tvalid, bus.m_tdata, bus.m_tuser, bus.m_tlast, in_sync, sync_err, frame_done);
    end
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if (bus.s_tready !== 1'b1) begin
      failed++;
      $display("FAIL ready_after_reset: got %b, required 1", bus.s_tready);
    end
    align();
  endtask

  task automatic test_full_frame();
    int se0, fd0, out0, t0;
    se0 = se_count; fd0 = fd_count; out0 = out_count;
    tests++;
    if (in_sync !== 1'b0) begin
      failed++;
      $display("FAIL in_sync_before_frame: got %b, required 0", in_sync);
    end
    for (int p = 0; p < 60; p++) begin
      if (p == 6) begin
        t0 = pcyc;
        send_packet(16'h0F00, 8'hEE, 1'b0, 1'b0, 1'b0);
        tests++;
        if (pcyc - t0 != 41) begin
          failed++;
          $display("FAIL discard_cycles: got %0d, required 41", pcyc - t0);
        end
      end
      send_packet(16'(p), 8'(p), 1'b1, p == 0, 1'b0);
      if (p == 0) begin
        tests++;
        if (in_sync !== 1'b1) begin
          failed++;
          $display("FAIL in_sync_after_first: got %b, required 1", in_sync);
        end
      end
    end
    wait_drain("frame");
    tests++;
    if (out_count - out0 != 4800) begin
      failed++;
      $display("FAIL frame_pixels: got %0d, required 4800", out_count - out0);
    end
    tests++;
    if (se_count != se0) begin
      failed++;
      $display("FAIL frame_sync_err: got %0d pulses, required 0", se_count - se0);
    end
    tests++;
    if (fd_count - fd0 != 1 || fd_gap != 1) begin
      failed++;
      $display("FAIL frame_done: got %0d pulses gap %0d, required 1 pulse gap 1", fd_count - fd0, fd_gap);
    end
  endtask

  task automatic test_late_start();
    int se0, out0;
    pulse_reset();
    se0 = se_count; out0 = out_count;
    send_packet(16'd7, 8'd7, 1'b0, 1'b0, 1'b0);
    send_packet(16'd8, 8'd8, 1'b0, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    align();
    tests++;
    if (in_sync !== 1'b0 || se_count != se0 || out_count != out0) begin
      failed++;
      $display("FAIL late_start_idle: got in_sync=%b sync_err=%0d pixels=%0d, required 0 0 0",
               in_sync, se_count - se0, out_count - out0);
    end
    send_packet(16'd0, 8'd0, 1'b1, 1'b1, 1'b1);
    wait_drain("late_start");
    tests++;
    if (in_sync !== 1'b1) begin
      failed++;
      $display("FAIL late_start_sync: got %b, required 1", in_sync);
    end
  endtask

  task automatic test_seq_error();
    int se0;
    se0 = se_count;
    for (int p = 1; p <= 3; p++) send_packet(16'(p), 8'(p), 1'b1, 1'b0, 1'b0);
    send_packet(16'd5, 8'd5, 1'b0, 1'b0, 1'b0);
    wait_drain("seq_error");
    tests++;
    if (se_count - se0 != 1 || in_sync !== 1'b0) begin
      failed++;
      $display("FAIL seq_error: got %0d pulses in_sync=%b, required 1 pulse in_sync=0", se_count - se0, in_sync);
    end
    send_packet(16'd6, 8'd6, 1'b0, 1'b0, 1'b0);
    send_packet(16'd0, 8'd0, 1'b1, 1'b1, 1'b0);
    wait_drain("resync");
    tests++;
    if (se_count - se0 != 1 || in_sync !== 1'b1) begin
      failed++;
      $display("FAIL resync: got %0d pulses in_sync=%b, required 1 pulse in_sync=1", se_count - se0, in_sync);
    end
  endtask

  task automatic test_stall();
    int s0;
    for (int p = 1; p <= 9; p++) send_packet(16'(p), 8'(p), 1'b1, 1'b0, 1'b0);
    wait_drain("pre_stall");
    s0 = stall_seen;
    stall_en = 1'b1;
    send_packet(16'd10, 8'd10, 1'b1, 1'b0, 1'b0);
    wait_drain("stall");
    stall_en = 1'b0;
    bus.m_tready = 1'b1;
    align();
    tests++;
    if (stall_seen == s0) begin
      failed++;
      $display("FAIL stall_exercised: got 0 stalled cycles, required at least 1");
    end
  endtask

  task automatic test_reset_mid();
    int se0;
    logic [15:0] p0;
    logic [15:0] p1;
    for (int p = 11; p <= 19; p++) send_packet(16'(p), 8'(p), 1'b1, 1'b0, 1'b0);
    send_word({8'hA5, 8'h5A, 8'd20, 8'h00});
    for (int i = 0; i < 10; i++) begin
      p0 = {8'd20, 8'(2 * i)};
      p1 = {8'd20, 8'(2 * i + 1)};
      exp_q.push_back(pix_t'{d: p0, u: 1'b0, l: 1'b0});
      exp_q.push_back(pix_t'{d: p1, u: 1'b0, l: 1'b0});
      send_word(enc(p0, p1));
    end
    tests++;
    if (bus.m_tvalid !== 1'b1) begin
      failed++;
      $display("FAIL mid_packet_valid: got %b, required 1", bus.m_tvalid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({bus.s_tready, bus.m_tvalid, bus.m_tdata, bus.m_tuser, bus.m_tlast, in_sync, sync_err, frame_done} !== '0) begin
      failed++;
      $display("FAIL async_reset: got s_tready=%b m_tvalid=%b m_tdata=%h user=%b last=%b in_sync=%b sync_err=%b frame_done=%b, required all 0",
               bus.s_tready, bus.m_tvalid, bus.m_tdata, bus.m_tuser, bus.m_tlast, in_sync, sync_err, frame_done);
    end
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    align();
    se0 = se_count;
    send_packet(16'd5, 8'd5, 1'b0, 1'b0, 1'b0);
    send_packet(16'd0, 8'd0, 1'b1, 1'b1, 1'b0);
    wait_drain("after_reset");
    tests++;
    if (in_sync !== 1'b1 || se_count != se0) begin
      failed++;
      $display("FAIL after_reset_sync: got in_sync=%b sync_err=%0d, required 1 and 0", in_sync, se_count - se0);
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_late_start();
    test_seq_error();
    test_stall();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
